// File: rtl/fb_stream_writer_if.sv
// Stream input and AXI4 write channels for the framebuffer writer.
// The master modport is the writer's view; slave is the memory/stream side.
interface fb_stream_writer_if;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;

  logic [3:0]  m_mem_axi_awid;
  logic [31:0] m_mem_axi_awaddr;
  logic [7:0]  m_mem_axi_awlen;
  logic [2:0]  m_mem_axi_awsize;
  logic [1:0]  m_mem_axi_awburst;
  logic        m_mem_axi_awlock;
  logic [3:0]  m_mem_axi_awcache;
  logic [2:0]  m_mem_axi_awprot;
  logic [3:0]  m_mem_axi_awqos;
  logic        m_mem_axi_awvalid;
  logic        m_mem_axi_awready;

  logic [31:0] m_mem_axi_wdata;
  logic [3:0]  m_mem_axi_wstrb;
  logic        m_mem_axi_wlast;
  logic        m_mem_axi_wvalid;
  logic        m_mem_axi_wready;

  logic [3:0]  m_mem_axi_bid;
  logic [1:0]  m_mem_axi_bresp;
  logic        m_mem_axi_bvalid;
  logic        m_mem_axi_bready;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    output s_axis_tready,
    output m_mem_axi_awid, m_mem_axi_awaddr, m_mem_axi_awlen, m_mem_axi_awsize,
           m_mem_axi_awburst, m_mem_axi_awlock, m_mem_axi_awcache, m_mem_axi_awprot,
           m_mem_axi_awqos, m_mem_axi_awvalid,
    input  m_mem_axi_awready,
    output m_mem_axi_wdata, m_mem_axi_wstrb, m_mem_axi_wlast, m_mem_axi_wvalid,
    input  m_mem_axi_wready,
    input  m_mem_axi_bresp, m_mem_axi_bvalid,
    output m_mem_axi_bready
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    input  s_axis_tready,
    input  m_mem_axi_awid, m_mem_axi_awaddr, m_mem_axi_awlen, m_mem_axi_awsize,
           m_mem_axi_awburst, m_mem_axi_awlock, m_mem_axi_awcache, m_mem_axi_awprot,
           m_mem_axi_awqos, m_mem_axi_awvalid,
    output m_mem_axi_awready,
    input  m_mem_axi_wdata, m_mem_axi_wstrb, m_mem_axi_wlast, m_mem_axi_wvalid,
    output m_mem_axi_wready,
    output m_mem_axi_bid, m_mem_axi_bresp, m_mem_axi_bvalid,
    input  m_mem_axi_bready
  );
endinterface

// File: rtl/fb_stream_writer.sv
// AXI4 write master filling one framebuffer per start from a pixel stream,
// as INCR bursts with a single burst outstanding.
module fb_stream_writer #(
  parameter int unsigned FB_SIZE_BEATS = 307200,
  parameter int unsigned BURST_LEN     = 16,
  parameter logic [3:0]  AXI_ID        = 4'd0
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] fbAddr,
  output logic        busy,
  output logic        done,
  output logic        frameError,
  fb_stream_writer_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] written_q, written_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [7:0]  awlen_q, awlen_d;
  logic        pad_q, pad_d;
  logic        short_err_q, short_err_d;
  logic        long_err_q, long_err_d;
  logic        resp_err_q, resp_err_d;

  logic        awvalid, wvalid, wlast, bready, tready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  function automatic logic [7:0] awlen_for(input logic [31:0] rem);
    logic [8:0] n;
    n = (rem >= 32'(BURST_LEN)) ? 9'(BURST_LEN) : rem[8:0];
    return 8'(n - 9'd1);
  endfunction

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      written_q   <= '0;
      beat_cnt_q  <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      pad_q       <= 1'b0;
      short_err_q <= 1'b0;
      long_err_q  <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      written_q   <= written_d;
      beat_cnt_q  <= beat_cnt_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      pad_q       <= pad_d;
      short_err_q <= short_err_d;
      long_err_q  <= long_err_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    written_d   = written_q;
    beat_cnt_d  = beat_cnt_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    pad_d       = pad_q;
    short_err_d = short_err_q;
    long_err_d  = long_err_q;
    resp_err_d  = resp_err_q;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    wlast       = 1'b0;
    bready      = 1'b0;
    tready      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = fbAddr;
          remaining_d = 32'(FB_SIZE_BEATS);
          written_d   = '0;
          awaddr_d    = fbAddr;
          awlen_d     = awlen_for(32'(FB_SIZE_BEATS));
          pad_d       = 1'b0;
          short_err_d = 1'b0;
          long_err_d  = 1'b0;
          resp_err_d  = 1'b0;
          state_d     = S_AW;
        end
      end
      S_AW: begin
        awvalid = 1'b1;
        if (bus.m_mem_axi_awready) begin
          beat_cnt_d = {1'b0, awlen_q} + 9'd1;
          state_d    = S_W;
        end
      end
      S_W: begin
        wlast = (beat_cnt_q == 9'd1);
        // After an early tlast the stream is left alone and the burst is padded with null-strobe beats.
        if (pad_q) begin
          wvalid = 1'b1;
        end else begin
          wvalid = bus.s_axis_tvalid;
          tready = bus.m_mem_axi_wready;
          wdata  = bus.s_axis_tdata;
          wstrb  = 4'hF;
        end
        if (wvalid && bus.m_mem_axi_wready) begin
          beat_cnt_d  = beat_cnt_q - 9'd1;
          remaining_d = remaining_q - 32'd1;
          written_d   = written_q + 32'd1;
          if (!pad_q) begin
            if (bus.s_axis_tlast && remaining_q != 32'd1) begin
              short_err_d = 1'b1;
              pad_d       = 1'b1;
            end
            if (!bus.s_axis_tlast && remaining_q == 32'd1) begin
              long_err_d = 1'b1;
            end
          end
          if (wlast) begin
            pad_d   = 1'b0;
            state_d = S_B;
          end
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bus.m_mem_axi_bvalid) begin
          if (bus.m_mem_axi_bresp != 2'b00) resp_err_d = 1'b1;
          if (remaining_q != 32'd0 && !short_err_q) begin
            awaddr_d = base_q + (written_q << 2);
            awlen_d  = awlen_for(remaining_q);
            state_d  = S_AW;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
  assign done       = (state_q == S_DONE);
  assign frameError = done && (short_err_q || long_err_q || resp_err_q);

  assign bus.s_axis_tready     = tready;
  assign bus.m_mem_axi_awid    = AXI_ID;
  assign bus.m_mem_axi_awaddr  = awaddr_q;
  assign bus.m_mem_axi_awlen   = awlen_q;
  assign bus.m_mem_axi_awsize  = 3'd2;
  assign bus.m_mem_axi_awburst = 2'd1;
  assign bus.m_mem_axi_awlock  = 1'b0;
  assign bus.m_mem_axi_awcache = 4'd0;
  assign bus.m_mem_axi_awprot  = 3'd0;
  assign bus.m_mem_axi_awqos   = 4'hF;
  assign bus.m_mem_axi_awvalid = awvalid;
  assign bus.m_mem_axi_wdata   = wdata;
  assign bus.m_mem_axi_wstrb   = wstrb;
  assign bus.m_mem_axi_wlast   = wlast;
  assign bus.m_mem_axi_wvalid  = wvalid;
  assign bus.m_mem_axi_bready  = bready;

endmodule
